l1_window_accumulator: RTL and testbench

L1_WINDOW_ACCUMULATOR -- requirements
Module: l1_window_accumulator

---
 rtl/l1_window_accumulator_pkg.sv | 19 +
 rtl/l1_window_accumulator_mag.sv | 18 +
 rtl/l1_window_accumulator.sv | 94 +++++++++
 tb/tb_l1_window_accumulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/l1_window_accumulator_pkg.sv
// Shared types and width helpers for the L1 window accumulator.
// Holds the FSM state encoding and the result-width derivation.
package l1_window_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Result width: M magnitudes of at most 2^(N-1) each fit in N + clog2(M) bits.
    function automatic int result_width(input int n, input int m);
        return n + $clog2(m);
    endfunction

    function automatic int count_width(input int m);
        return $clog2(m);
    endfunction

endpackage

// File: rtl/l1_window_accumulator_mag.sv
// Purely combinational two's-complement magnitude.
// The most negative input maps to 2^(N-1), which still fits in N unsigned bits.
module sample_magnitude #(
    parameter int N = 8
) (
    input  logic signed [N-1:0] sample_i,
    output logic        [N-1:0] mag_o
);

    always_comb begin
        if (sample_i[N-1]) begin
            mag_o = ~sample_i + 1'b1;
        end else begin
            mag_o = sample_i;
        end
    end

endmodule

// File: rtl/l1_window_accumulator.sv
// Accumulates the magnitudes of M accepted samples and presents the sum
// through a valid/ready output handshake; input stalls while a result is held.
module l1_window_accumulator
    import l1_window_accumulator_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [N-1:0]           sample,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [result_width(N, M)-1:0] sum
);

    localparam int W     = result_width(N, M);
    localparam int CNT_W = count_width(M);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     mag;
    logic [W-1:0]     mag_ext;
    logic             accept;
    logic             last;

    sample_magnitude #(.N(N)) u_mag (
        .sample_i (sample),
        .mag_o    (mag)
    );

    assign mag_ext = {{(W - N){1'b0}}, mag};
    // clear takes precedence over a sample offered in the same cycle
    assign accept  = (state_q == ST_ACCUM) && in_valid && !clear;
    assign last    = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && last) state_d = ST_HOLD;
            ST_HOLD:  if (out_ready)      state_d = ST_ACCUM;
            default:                      state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (state_q == ST_ACCUM) begin
            if (clear) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (accept) begin
                if (last) begin
                    sum_d = acc_q + mag_ext;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_q + mag_ext;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_HOLD);
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_l1_window_accumulator.sv
// Directed and randomly gapped stimulus for l1_window_accumulator (N=8, M=4),
// checked against hand-computed values and a magnitude-sum model.
module tb_l1_window_accumulator;

    localparam int N = 8;
    localparam int M = 4;
    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] sample;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        sum;

    int n_checks = 0;
    int n_fail   = 0;

    l1_window_accumulator #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sample    (sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for one cycle; in_valid is left high for back-to-back use.
    task automatic push(input int v);
        in_valid = 1'b1;
        sample   = N'(v);
        tick();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic window_of_ones(input string tag);
        for (int i = 0; i < M; i++) begin
            push(1);
            if (i < M - 1) check({tag, "_ov_mid"}, int'(out_valid), 0);
        end
        in_valid = 1'b0;
        check({tag, "_ov"}, int'(out_valid), 1);
        check({tag, "_sum"}, int'(sum), 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vals[4];
        int exp_sum;
        int s;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; sample = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ov", int'(out_valid), 0);
        check("rst_ir", int'(in_ready), 1);
        check("rst_sum", int'(sum), 0);

        // back-to-back 3, -5, 0, 7
        vals = '{3, -5, 0, 7};
        for (int i = 0; i < M; i++) begin
            push(vals[i]);
            if (i < M - 1) check("b2b_ov_mid", int'(out_valid), 0);
        end
        in_valid = 1'b0;
        check("b2b_ov", int'(out_valid), 1);
        check("b2b_sum", int'(sum), 15);
        check("b2b_ir", int'(in_ready), 0);
        drain();
        check("b2b_exit_ov", int'(out_valid), 0);
        check("b2b_exit_ir", int'(in_ready), 1);

        // most negative value four times, no wrap
        for (int i = 0; i < M; i++) push(-128);
        in_valid = 1'b0;
        check("neg_ov", int'(out_valid), 1);
        check("neg_sum", int'(sum), 512);

        // stall in HOLD with in_valid high and a clear pulse
        in_valid = 1'b1;
        sample   = 8'sd50;
        for (int c = 0; c < 5; c++) begin
            clear = (c == 2);
            tick();
            check("hold_ov", int'(out_valid), 1);
            check("hold_ir", int'(in_ready), 0);
            check("hold_sum", int'(sum), 512);
        end
        clear = 1'b0;
        drain();
        check("hold_exit_ov", int'(out_valid), 0);
        check("hold_exit_ir", int'(in_ready), 1);
        window_of_ones("hold_after");
        drain();

        // partial window aborted by clear; clear beats the concurrent sample
        push(10);
        push(-20);
        clear = 1'b1;
        push(99);
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_ov", int'(out_valid), 0);
        window_of_ones("clr");
        drain();

        // reset mid-window
        push(5); push(5); push(5);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ov", int'(out_valid), 0);
        check("rstmid_ir", int'(in_ready), 1);
        check("rstmid_sum", int'(sum), 0);
        window_of_ones("rstmid_after");

        // reset while holding a result
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("rsthold_ov", int'(out_valid), 0);
        check("rsthold_ir", int'(in_ready), 1);
        check("rsthold_sum", int'(sum), 0);
        window_of_ones("rsthold_after");
        drain();

        // randomly gapped windows against a magnitude-sum model
        for (int w = 0; w < 1000; w++) begin
            exp_sum = 0;
            for (int k = 0; k < M; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    sample   = N'($urandom);
                    tick();
                end
                s = $urandom_range(0, 255) - 128;
                exp_sum += (s < 0) ? -s : s;
                push(s);
            end
            in_valid = 1'b0;
            check("rnd_ov", int'(out_valid), 1);
            check("rnd_sum", int'(sum), exp_sum);
            for (int d = $urandom_range(0, 2); d > 0; d--) begin
                in_valid = 1'($urandom);
                tick();
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
